// File: rtl/cpu_fetch.sv
// Instruction fetch stage: owns the fetch PC, waits out I-cache misses, and hands
// one instruction at a time to decode through a registered single-entry slot.
module cpu_fetch #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        i_clock,
   input  logic        i_reset,
   output logic [31:0] o_icache_pc,
   input  logic [31:0] i_icache_rdata,
   input  logic        i_icache_ready,
   input  logic        i_jump,
   input  logic [31:0] i_jump_pc,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_instruction,
   output logic [31:0] o_pc
);

   typedef enum logic {
      IDLE,
      FETCH
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pend_pc;
   logic        pend;

   logic        transfer;
   logic        slot_free;
   logic [31:0] jump_target;

   assign transfer    = o_valid && i_ready;
   assign slot_free   = !o_valid || i_ready;
   assign jump_target = {i_jump_pc[31:2], 2'b00};

   // The cache sees the registered PC only, so nothing on the input side can glitch it.
   assign o_icache_pc = pc;

   // NOTE: every register here sits in one clocked block with non-blocking updates, so
   // all of them observe the same pre-edge values regardless of statement order.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state         <= IDLE;
         pc            <= {RESET_VECTOR[31:2], 2'b00};
         pend          <= 1'b0;
         pend_pc       <= 32'h0;
         o_valid       <= 1'b0;
         o_instruction <= 32'h0;
         o_pc          <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               state   <= FETCH;
               o_valid <= 1'b0;
               if (i_jump) pc <= jump_target;
            end
            FETCH: begin
               if (i_jump) begin
                  // A redirect also flushes decode, so the slot empties either way.
                  o_valid <= 1'b0;
                  if (i_icache_ready) begin
                     pc   <= jump_target;
                     pend <= 1'b0;
                  end else begin
                     pend    <= 1'b1;
                     pend_pc <= jump_target;
                  end
               end else if (i_icache_ready && pend) begin
                  // The word that just arrived belongs to the abandoned path.
                  pc   <= pend_pc;
                  pend <= 1'b0;
                  if (transfer) o_valid <= 1'b0;
               end else if (i_icache_ready && slot_free) begin
                  o_valid       <= 1'b1;
                  o_instruction <= i_icache_rdata;
                  o_pc          <= pc;
                  pc            <= pc + 32'd4;
               end else if (transfer) begin
                  o_valid <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: a miss-capable cache model returning rdata=pc, directed
// scenarios with literal expectations, then a randomized run against a drain-then-fill model.
module tb_cpu_fetch;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic [31:0] o_icache_pc;
   logic [31:0] i_icache_rdata;
   logic        i_icache_ready;
   logic        i_jump;
   logic [31:0] i_jump_pc;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_instruction;
   logic [31:0] o_pc;

   always #5 i_clock = ~i_clock;

   cpu_fetch #(.RESET_VECTOR(RV)) dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .o_icache_pc    (o_icache_pc),
      .i_icache_rdata (i_icache_rdata),
      .i_icache_ready (i_icache_ready),
      .i_jump         (i_jump),
      .i_jump_pc      (i_jump_pc),
      .o_valid        (o_valid),
      .i_ready        (i_ready),
      .o_instruction  (o_instruction),
      .o_pc           (o_pc)
   );

   int checks = 0;
   int errors = 0;

   // Reference state: what decode should see, and where fetch is headed next.
   bit          m_started;
   bit          m_valid;
   logic [31:0] m_pc, m_instr, m_fetch_pc;
   bit          m_redirect_waiting;
   logic [31:0] m_redirect_to;

   // Cache model: hits answer at once, misses answer on the 4th cycle after presentation.
   logic [31:0] c_pc;
   int          c_age;
   bit          c_miss, c_fresh;
   int          miss_pct = 0;
   bit          force_en = 1'b0;
   logic [31:0] force_miss_pc = 32'h0;
   bit          rst_level;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_started          = 1'b0;
      m_valid            = 1'b0;
      m_pc               = 32'h0;
      m_instr            = 32'h0;
      m_fetch_pc         = {RV[31:2], 2'b00};
      m_redirect_waiting = 1'b0;
      m_redirect_to      = 32'h0;
      c_fresh            = 1'b1;
   endtask

   // One clock: compare at the falling edge, then drive the inputs for the next rising edge
   // and advance the reference by what that edge must do.
   task automatic cycle(input bit rdy, input bit jmp, input logic [31:0] jpc);
      bit          cready;
      logic [31:0] cdata;
      @(negedge i_clock);
      check("valid", o_valid, m_valid);
      check("out_pc", o_pc, m_pc);
      check("instr", o_instruction, m_instr);
      check("icache_pc", o_icache_pc, m_fetch_pc);
      check("align", {30'h0, o_pc[1:0] | o_icache_pc[1:0]}, 32'h0);

      if (c_fresh || o_icache_pc !== c_pc) begin
         c_pc    = o_icache_pc;
         c_age   = 0;
         c_miss  = (force_en && c_pc == force_miss_pc) || ($urandom_range(99) < miss_pct);
         c_fresh = 1'b0;
      end else begin
         c_age++;
      end
      cready = !c_miss || c_age >= 4;
      cdata  = cready ? c_pc : $urandom;

      i_reset        = rst_level;
      i_ready        = rdy;
      i_jump         = jmp;
      i_jump_pc      = jpc;
      i_icache_ready = cready;
      i_icache_rdata = cdata;

      if (rst_level) begin
         model_reset();
      end else if (!m_started) begin
         m_started = 1'b1;
         if (jmp) m_fetch_pc = jpc & ~32'h3;
      end else begin
         // Decode drains first; then the redirect or the arriving word decides the refill.
         if (m_valid && rdy) m_valid = 1'b0;
         if (jmp) begin
            m_valid = 1'b0;
            if (cready) begin
               m_fetch_pc         = jpc & ~32'h3;
               m_redirect_waiting = 1'b0;
            end else begin
               m_redirect_waiting = 1'b1;
               m_redirect_to      = jpc & ~32'h3;
            end
         end else if (cready && m_redirect_waiting) begin
            m_fetch_pc         = m_redirect_to;
            m_redirect_waiting = 1'b0;
         end else if (cready && !m_valid) begin
            m_valid    = 1'b1;
            m_pc       = m_fetch_pc;
            m_instr    = cdata;
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
   endtask

   task automatic reset_and_start();
      rst_level = 1'b1;
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      rst_level = 1'b0;
      cycle(1, 0, 0);
      check("rst_valid", o_valid, 0);
      check("rst_icache", o_icache_pc, RV);
      cycle(1, 0, 0);
      check("idle_valid", o_valid, 0);
      check("idle_icache", o_icache_pc, RV);
   endtask

   initial begin
      i_reset = 1'b1; i_ready = 1'b1; i_jump = 1'b0; i_jump_pc = 32'h0;
      i_icache_ready = 1'b0; i_icache_rdata = 32'h0;
      rst_level = 1'b1;
      c_pc = 32'h0; c_age = 0; c_miss = 1'b0;
      model_reset();

      // Streaming hits: 0,4,8,12 on consecutive cycles.
      reset_and_start();
      for (int k = 0; k < 4; k++) begin
         cycle(1, 0, 0);
         check("seq_valid", o_valid, 1);
         check("seq_pc", o_pc, 32'(4 * k));
         check("seq_instr", o_instruction, 32'(4 * k));
      end

      // Backpressure while o_pc=8.
      reset_and_start();
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      check("bp_pre_pc", o_pc, 32'd4);
      for (int k = 0; k < 5; k++) begin
         cycle(0, 0, 0);
         check("bp_valid", o_valid, 1);
         check("bp_pc", o_pc, 32'd8);
         check("bp_icache", o_icache_pc, 32'd12);
      end
      force_en = 1'b1;
      force_miss_pc = 32'd16;
      cycle(1, 0, 0);
      check("bp_release_pc", o_pc, 32'd8);
      cycle(1, 0, 0);
      check("bp_next_valid", o_valid, 1);
      check("bp_next_pc", o_pc, 32'd12);
      check("miss_present", o_icache_pc, 32'd16);

      // Jump two cycles into the miss on 16.
      cycle(1, 0, 0);
      check("miss_icache1", o_icache_pc, 32'd16);
      cycle(1, 1, 32'h100);
      check("miss_icache2", o_icache_pc, 32'd16);
      cycle(1, 0, 0);
      check("miss_icache3", o_icache_pc, 32'd16);
      check("miss_valid3", o_valid, 0);
      cycle(1, 0, 0);
      check("miss_icache4", o_icache_pc, 32'd16);
      check("miss_valid4", o_valid, 0);
      cycle(1, 0, 0);
      check("redir_icache", o_icache_pc, 32'h100);
      check("redir_valid", o_valid, 0);

      // Jump on a hit to a misaligned target.
      cycle(1, 1, 32'h203);
      check("redir_out_valid", o_valid, 1);
      check("redir_out_pc", o_pc, 32'h100);
      cycle(1, 0, 0);
      check("hitjmp_icache", o_icache_pc, 32'h200);
      check("hitjmp_valid", o_valid, 0);

      // Wrap from the top of the address space.
      cycle(1, 1, 32'hFFFF_FFFC);
      check("hitjmp_out_pc", o_pc, 32'h200);
      cycle(1, 0, 0);
      check("wrap_icache", o_icache_pc, 32'hFFFF_FFFC);
      cycle(1, 0, 0);
      check("wrap_pc_top", o_pc, 32'hFFFF_FFFC);
      cycle(1, 1, 32'h3C);
      check("wrap_pc_zero", o_pc, 32'h0);
      check("wrap_valid", o_valid, 1);

      // Asynchronous reset while 0x40 is missing and decode is stalled.
      force_miss_pc = 32'h40;
      cycle(1, 0, 0);
      cycle(0, 0, 0);
      check("arst_pre_valid", o_valid, 1);
      check("arst_pre_icache", o_icache_pc, 32'h40);
      cycle(0, 0, 0);
      #2;
      rst_level = 1'b1;
      i_reset   = 1'b1;
      #1;
      check("arst_valid", o_valid, 0);
      check("arst_icache", o_icache_pc, RV);
      check("arst_pc", o_pc, 32'h0);
      check("arst_instr", o_instruction, 32'h0);
      model_reset();
      force_en = 1'b0;
      cycle(1, 0, 0);
      rst_level = 1'b0;
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      check("arst_first_icache", o_icache_pc, RV);
      cycle(1, 0, 0);
      check("arst_first_pc", o_pc, RV);
      check("arst_first_valid", o_valid, 1);

      // Randomized traffic: misses, stalls, redirects and the occasional reset.
      miss_pct = 30;
      for (int n = 0; n < 4000; n++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                        : $urandom;
         rst_level = ($urandom_range(299) == 0);
         cycle($urandom_range(99) < 70, $urandom_range(99) < 8, tgt);
      end
      rst_level = 1'b0;
      cycle(1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
